// File: rtl/mi_pkg.sv
// Shared types and defaults for the memory-interface arbiter.
package mi_pkg;

  localparam int MI_AW = 24;
  localparam int MI_LW = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } mi_state_e;

  // Port 1 has fixed priority unless port 0 has waited out its starvation budget.
  function automatic logic pick_winner(input logic force0, input logic v0, input logic v1);
    if (force0 && v0) begin
      return 1'b0;
    end
    return v1;
  endfunction

endpackage

// File: rtl/mi_arb_prio.sv
// Winner selection between the two requesters plus the port-0 starvation counter.
module mi_arb_prio
  import mi_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic clk_4x_s,
  input  logic rst,
  input  logic m0_valid,
  input  logic m1_valid,
  input  logic idle,
  input  logic owner,
  output logic winner,
  output logic grant
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait0;
  logic          force0;
  logic          wait0_inc;

  // Arbitration is only meaningful while the FSM is idle; grant is the accept strobe.
  always_comb begin
    force0    = (wait0 == WAIT_MAX);
    grant     = idle & (m0_valid | m1_valid);
    winner    = pick_winner(force0, m0_valid, m1_valid);
    wait0_inc = m0_valid & (owner | ~idle);
  end

  // Count cycles port 0 is kept waiting; a port-0 grant clears it, saturation forces it next.
  always_ff @(posedge clk_4x_s) begin
    if (rst) begin
      wait0 <= '0;
    end else if (grant && (winner == 1'b0)) begin
      wait0 <= '0;
    end else if (wait0_inc && (wait0 != WAIT_MAX)) begin
      wait0 <= wait0 + WW'(1);
    end
  end

endmodule

// File: rtl/mi_arbiter.sv
// Two-port arbiter sharing one PSRAM mi_* port; grant is locked for the whole burst.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | arbitrate between m0/m1, register owner on a grant
// CMD     | mi_valid held, command muxed from owner, wait for mi_ready
// DATA    | beats routed to owner until last read or last write beat
module mi_arbiter
  import mi_pkg::*;
#(
  parameter int AW       = MI_AW,
  parameter int LW       = MI_LW,
  parameter int MAX_WAIT = 64
) (
  input  logic          clk_4x_s,
  input  logic          rst,
  // port 0 (cache)
  input  logic [AW-1:0] m0_addr,
  input  logic [LW-1:0] m0_len,
  input  logic          m0_rw,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wmsk,
  output logic          m0_wack,
  output logic          m0_wlast,
  output logic [31:0]   m0_rdata,
  output logic          m0_rstb,
  output logic          m0_rlast,
  // port 1 (streaming DMA)
  input  logic [AW-1:0] m1_addr,
  input  logic [LW-1:0] m1_len,
  input  logic          m1_rw,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wmsk,
  output logic          m1_wack,
  output logic          m1_wlast,
  output logic [31:0]   m1_rdata,
  output logic          m1_rstb,
  output logic          m1_rlast,
  // controller side
  output logic [AW-1:0] mi_addr,
  output logic [LW-1:0] mi_len,
  output logic          mi_rw,
  output logic          mi_valid,
  input  logic          mi_ready,
  output logic [31:0]   mi_wdata,
  output logic [3:0]    mi_wmsk,
  input  logic          mi_wack,
  input  logic          mi_wlast,
  input  logic [31:0]   mi_rdata,
  input  logic          mi_rstb,
  input  logic          mi_rlast,
  // status
  output logic          busy,
  output logic          owner
);

  mi_state_e state_q;
  mi_state_e state_d;
  logic      owner_q;
  logic      winner;
  logic      grant;
  logic      burst_end;

  mi_arb_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk_4x_s(clk_4x_s),
    .rst     (rst),
    .m0_valid(m0_valid),
    .m1_valid(m1_valid),
    .idle    (state_q == ST_IDLE),
    .owner   (owner_q),
    .winner  (winner),
    .grant   (grant)
  );

  // The burst length field is never interpreted; only last-beat strobes end a burst.
  assign burst_end = (mi_rstb & mi_rlast) | (mi_wack & mi_wlast);

  // State and owner registers; owner keeps the last grantee once the burst ends.
  always_ff @(posedge clk_4x_s) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= winner;
      end
    end
  end

  // Next-state: one cycle to grant, hold CMD until accepted, DATA until last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant)     state_d = ST_CMD;
      ST_CMD:  if (mi_ready)  state_d = ST_DATA;
      ST_DATA: if (burst_end) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Command/data muxes follow owner; handshakes reach only the owning port.
  always_comb begin
    mi_addr  = owner_q ? m1_addr  : m0_addr;
    mi_len   = owner_q ? m1_len   : m0_len;
    mi_rw    = owner_q ? m1_rw    : m0_rw;
    mi_wdata = owner_q ? m1_wdata : m0_wdata;
    mi_wmsk  = owner_q ? m1_wmsk  : m0_wmsk;
    mi_valid = 1'b0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_wack  = 1'b0;
    m1_wack  = 1'b0;
    m0_wlast = 1'b0;
    m1_wlast = 1'b0;
    m0_rstb  = 1'b0;
    m1_rstb  = 1'b0;
    m0_rlast = 1'b0;
    m1_rlast = 1'b0;
    case (state_q)
      ST_CMD: begin
        mi_valid = 1'b1;
        m0_ready = mi_ready & ~owner_q;
        m1_ready = mi_ready &  owner_q;
      end
      ST_DATA: begin
        m0_rstb  = mi_rstb  & ~owner_q;
        m1_rstb  = mi_rstb  &  owner_q;
        m0_rlast = mi_rlast & ~owner_q;
        m1_rlast = mi_rlast &  owner_q;
        m0_wack  = mi_wack  & ~owner_q;
        m1_wack  = mi_wack  &  owner_q;
        m0_wlast = mi_wlast & ~owner_q;
        m1_wlast = mi_wlast &  owner_q;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; the strobes above say who should take it.
  assign m0_rdata = mi_rdata;
  assign m1_rdata = mi_rdata;

  assign busy  = (state_q != ST_IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_mi_arbiter.sv
// Directed bench for mi_arbiter: read, arbitration, write with stall, reset, starvation.
module tb_mi_arbiter;

   localparam int AW = 24;
   localparam int LW = 7;
   localparam int MW = 16;

   logic          clk_4x_s = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] m0_addr, m1_addr, mi_addr;
   logic [LW-1:0] m0_len, m1_len, mi_len;
   logic          m0_rw, m1_rw, mi_rw;
   logic          m0_valid, m1_valid, mi_valid;
   logic          m0_ready, m1_ready, mi_ready;
   logic [31:0]   m0_wdata, m1_wdata, mi_wdata;
   logic [3:0]    m0_wmsk, m1_wmsk, mi_wmsk;
   logic          m0_wack, m1_wack, mi_wack;
   logic          m0_wlast, m1_wlast, mi_wlast;
   logic [31:0]   m0_rdata, m1_rdata, mi_rdata;
   logic          m0_rstb, m1_rstb, mi_rstb;
   logic          m0_rlast, m1_rlast, mi_rlast;
   logic          busy, owner;

   int checks = 0;
   int failures = 0;
   int pulses;
   int first0;
   int m1n;

   mi_arbiter #(.AW(AW), .LW(LW), .MAX_WAIT(MW)) dut (
      .clk_4x_s(clk_4x_s), .rst(rst),
      .m0_addr(m0_addr), .m0_len(m0_len), .m0_rw(m0_rw), .m0_valid(m0_valid),
      .m0_ready(m0_ready), .m0_wdata(m0_wdata), .m0_wmsk(m0_wmsk), .m0_wack(m0_wack),
      .m0_wlast(m0_wlast), .m0_rdata(m0_rdata), .m0_rstb(m0_rstb), .m0_rlast(m0_rlast),
      .m1_addr(m1_addr), .m1_len(m1_len), .m1_rw(m1_rw), .m1_valid(m1_valid),
      .m1_ready(m1_ready), .m1_wdata(m1_wdata), .m1_wmsk(m1_wmsk), .m1_wack(m1_wack),
      .m1_wlast(m1_wlast), .m1_rdata(m1_rdata), .m1_rstb(m1_rstb), .m1_rlast(m1_rlast),
      .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
      .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wmsk(mi_wmsk), .mi_wack(mi_wack),
      .mi_wlast(mi_wlast), .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast),
      .busy(busy), .owner(owner)
   );

   always #5 clk_4x_s = ~clk_4x_s;

   task automatic tick();
      @(posedge clk_4x_s);
      #2;
   endtask

   task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m0_addr = '0; m0_len = '0; m0_rw = 1'b0; m0_valid = 1'b0; m0_wdata = '0; m0_wmsk = '0;
      m1_addr = '0; m1_len = '0; m1_rw = 1'b0; m1_valid = 1'b0; m1_wdata = '0; m1_wmsk = '0;
      mi_ready = 1'b0; mi_wack = 1'b0; mi_wlast = 1'b0; mi_rdata = '0; mi_rstb = 1'b0; mi_rlast = 1'b0;

      // reset, with stray controller strobes that must not leak through
      rst = 1'b1;
      tick();
      mi_rstb = 1'b1; mi_wack = 1'b1; mi_rlast = 1'b1; mi_wlast = 1'b1;
      tick();
      #1;
      checks++; if (busy !== 1'b0) fail("rst_busy", busy, 1'b0);
      checks++; if (owner !== 1'b0) fail("rst_owner", owner, 1'b0);
      checks++; if (mi_valid !== 1'b0) fail("rst_mi_valid", mi_valid, 1'b0);
      checks++; if (m0_ready !== 1'b0) fail("rst_m0_ready", m0_ready, 1'b0);
      checks++; if (m1_ready !== 1'b0) fail("rst_m1_ready", m1_ready, 1'b0);
      checks++; if (m0_rstb !== 1'b0) fail("rst_m0_rstb", m0_rstb, 1'b0);
      checks++; if (m1_rstb !== 1'b0) fail("rst_m1_rstb", m1_rstb, 1'b0);
      checks++; if (m0_wack !== 1'b0) fail("rst_m0_wack", m0_wack, 1'b0);
      checks++; if (mi_addr !== 24'h0) fail("rst_mi_addr", mi_addr, 24'h0);
      mi_rstb = 1'b0; mi_wack = 1'b0; mi_rlast = 1'b0; mi_wlast = 1'b0;
      rst = 1'b0;
      tick();

      // single 8-beat read from port 1
      m1_addr = 24'h000100; m1_len = 7'd7; m1_rw = 1'b1; m1_valid = 1'b1;
      #1;
      checks++; if (mi_valid !== 1'b0) fail("rd_idle_mi_valid", mi_valid, 1'b0);
      tick();
      #1;
      checks++; if (mi_valid !== 1'b1) fail("rd_cmd_mi_valid", mi_valid, 1'b1);
      checks++; if (mi_addr !== 24'h000100) fail("rd_cmd_addr", mi_addr, 24'h000100);
      checks++; if (mi_len !== 7'd7) fail("rd_cmd_len", mi_len, 7'd7);
      checks++; if (mi_rw !== 1'b1) fail("rd_cmd_rw", mi_rw, 1'b1);
      checks++; if (owner !== 1'b1) fail("rd_cmd_owner", owner, 1'b1);
      checks++; if (m1_ready !== 1'b0) fail("rd_cmd_m1_ready_early", m1_ready, 1'b0);
      mi_ready = 1'b1;
      #1;
      checks++; if (m1_ready !== 1'b1) fail("rd_m1_ready", m1_ready, 1'b1);
      checks++; if (m0_ready !== 1'b0) fail("rd_m0_ready", m0_ready, 1'b0);
      tick();
      m1_valid = 1'b0; mi_ready = 1'b0;
      #1;
      checks++; if (m1_ready !== 1'b0) fail("rd_data_m1_ready_low", m1_ready, 1'b0);
      pulses = 0;
      for (int b = 0; b < 8; b++) begin
         mi_rstb = 1'b1; mi_rdata = 32'hA0 + 32'(b); mi_rlast = (b == 7);
         #1;
         if (m1_rstb === 1'b1) pulses++;
         checks++; if (m1_rdata !== 32'hA0 + 32'(b)) fail("rd_m1_rdata", m1_rdata, 32'hA0 + 32'(b));
         checks++; if (m1_rlast !== (b == 7)) fail("rd_m1_rlast", m1_rlast, (b == 7));
         checks++; if (m0_rstb !== 1'b0) fail("rd_m0_rstb", m0_rstb, 1'b0);
         checks++; if (busy !== 1'b1) fail("rd_busy", busy, 1'b1);
         tick();
      end
      mi_rstb = 1'b0; mi_rlast = 1'b0;
      #1;
      checks++; if (pulses !== 8) fail("rd_m1_rstb_pulses", pulses, 8);
      checks++; if (busy !== 1'b0) fail("rd_busy_after", busy, 1'b0);

      // simultaneous requests: port 1 first, port 0 two cycles after rlast
      m0_addr = 24'h000200; m0_len = 7'd1; m0_rw = 1'b1; m0_valid = 1'b1;
      m1_addr = 24'h000300; m1_len = 7'd0; m1_rw = 1'b1; m1_valid = 1'b1;
      tick();
      #1;
      checks++; if (owner !== 1'b1) fail("sim_first_owner", owner, 1'b1);
      checks++; if (mi_addr !== 24'h000300) fail("sim_first_addr", mi_addr, 24'h000300);
      mi_ready = 1'b1;
      #1;
      checks++; if (m1_ready !== 1'b1) fail("sim_m1_ready", m1_ready, 1'b1);
      checks++; if (m0_ready !== 1'b0) fail("sim_m0_ready", m0_ready, 1'b0);
      tick();
      m1_valid = 1'b0; mi_ready = 1'b0; mi_rstb = 1'b1; mi_rlast = 1'b1; mi_rdata = 32'h11;
      #1;
      checks++; if (m1_rstb !== 1'b1) fail("sim_m1_rstb", m1_rstb, 1'b1);
      checks++; if (m0_rstb !== 1'b0) fail("sim_m0_rstb", m0_rstb, 1'b0);
      tick();
      mi_rstb = 1'b0; mi_rlast = 1'b0;
      #1;
      checks++; if (mi_valid !== 1'b0) fail("sim_gap_mi_valid", mi_valid, 1'b0);
      checks++; if (busy !== 1'b0) fail("sim_gap_busy", busy, 1'b0);
      tick();
      #1;
      checks++; if (mi_valid !== 1'b1) fail("sim_second_mi_valid", mi_valid, 1'b1);
      checks++; if (mi_addr !== 24'h000200) fail("sim_second_addr", mi_addr, 24'h000200);
      checks++; if (owner !== 1'b0) fail("sim_second_owner", owner, 1'b0);
      mi_ready = 1'b1;
      #1;
      checks++; if (m0_ready !== 1'b1) fail("sim_m0_ready2", m0_ready, 1'b1);
      checks++; if (m1_ready !== 1'b0) fail("sim_m1_ready2", m1_ready, 1'b0);
      tick();
      m0_valid = 1'b0; mi_ready = 1'b0; mi_rstb = 1'b1; mi_rlast = 1'b0;
      #1;
      checks++; if (m0_rstb !== 1'b1) fail("sim_m0_rstb", m0_rstb, 1'b1);
      checks++; if (m1_rstb !== 1'b0) fail("sim_m1_rstb_off", m1_rstb, 1'b0);
      tick();
      mi_rlast = 1'b1;
      #1;
      checks++; if (m0_rlast !== 1'b1) fail("sim_m0_rlast", m0_rlast, 1'b1);
      tick();
      mi_rstb = 1'b0; mi_rlast = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) fail("sim_busy_after", busy, 1'b0);

      // port-0 write, command stalled 5 cycles, wack every other cycle
      m0_addr = 24'h000400; m0_len = 7'd3; m0_rw = 1'b0; m0_valid = 1'b1;
      m1_wdata = 32'hFFFF_FFFF; m1_wmsk = 4'hF;
      tick();
      for (int s = 0; s < 5; s++) begin
         #1;
         checks++; if (mi_valid !== 1'b1) fail("st_mi_valid", mi_valid, 1'b1);
         checks++; if (mi_addr !== 24'h000400) fail("st_addr", mi_addr, 24'h000400);
         checks++; if (mi_len !== 7'd3) fail("st_len", mi_len, 7'd3);
         checks++; if (m0_ready !== 1'b0) fail("st_m0_ready", m0_ready, 1'b0);
         tick();
      end
      mi_ready = 1'b1;
      #1;
      checks++; if (m0_ready !== 1'b1) fail("st_m0_ready_go", m0_ready, 1'b1);
      checks++; if (mi_addr !== 24'h000400) fail("st_addr_go", mi_addr, 24'h000400);
      tick();
      m0_valid = 1'b0; mi_ready = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         m0_wdata = 32'hD000_0000 + 32'(c); m0_wmsk = 4'(c);
         mi_wack = (c % 2 == 1); mi_wlast = (c == 7);
         #1;
         if (m0_wack === 1'b1) pulses++;
         checks++; if (mi_wdata !== 32'hD000_0000 + 32'(c)) fail("wr_wdata", mi_wdata, 32'hD000_0000 + 32'(c));
         checks++; if (mi_wmsk !== 4'(c)) fail("wr_wmsk", mi_wmsk, 4'(c));
         checks++; if (m0_wlast !== (c == 7)) fail("wr_m0_wlast", m0_wlast, (c == 7));
         checks++; if (m1_wack !== 1'b0) fail("wr_m1_wack", m1_wack, 1'b0);
         tick();
      end
      mi_wack = 1'b0; mi_wlast = 1'b0;
      #1;
      checks++; if (pulses !== 4) fail("wr_m0_wack_pulses", pulses, 4);
      checks++; if (busy !== 1'b0) fail("wr_busy_after", busy, 1'b0);

      // reset in the middle of an 8-beat port-1 read
      m0_addr = '0; m0_len = '0; m0_rw = 1'b0; m0_wdata = '0; m0_wmsk = '0;
      m1_addr = 24'h000500; m1_len = 7'd7; m1_rw = 1'b1; m1_valid = 1'b1;
      tick();
      mi_ready = 1'b1;
      tick();
      m1_valid = 1'b0; mi_ready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         mi_rstb = 1'b1; mi_rdata = 32'(b);
         tick();
      end
      rst = 1'b1;
      #1;
      checks++; if (m1_rstb !== 1'b1) fail("mr_pre_rst_rstb", m1_rstb, 1'b1);
      tick();
      #1;
      checks++; if (busy !== 1'b0) fail("mr_busy", busy, 1'b0);
      checks++; if (owner !== 1'b0) fail("mr_owner", owner, 1'b0);
      checks++; if (mi_valid !== 1'b0) fail("mr_mi_valid", mi_valid, 1'b0);
      checks++; if (m1_rstb !== 1'b0) fail("mr_m1_rstb", m1_rstb, 1'b0);
      checks++; if (m0_rstb !== 1'b0) fail("mr_m0_rstb", m0_rstb, 1'b0);
      checks++; if (mi_addr !== 24'h0) fail("mr_mi_addr", mi_addr, 24'h0);
      checks++; if (mi_wmsk !== 4'h0) fail("mr_mi_wmsk", mi_wmsk, 4'h0);
      rst = 1'b0; mi_rstb = 1'b0;
      m0_addr = 24'h000600; m0_len = 7'd0; m0_rw = 1'b1; m0_valid = 1'b1;
      tick();
      #1;
      checks++; if (mi_valid !== 1'b1) fail("mr_new_mi_valid", mi_valid, 1'b1);
      checks++; if (mi_addr !== 24'h000600) fail("mr_new_addr", mi_addr, 24'h000600);
      mi_ready = 1'b1;
      #1;
      checks++; if (m0_ready !== 1'b1) fail("mr_new_m0_ready", m0_ready, 1'b1);
      tick();
      m0_valid = 1'b0; mi_ready = 1'b0; mi_rstb = 1'b1; mi_rlast = 1'b1; mi_rdata = 32'h55;
      #1;
      checks++; if (m0_rstb !== 1'b1) fail("mr_new_m0_rstb", m0_rstb, 1'b1);
      checks++; if (m0_rdata !== 32'h55) fail("mr_new_m0_rdata", m0_rdata, 32'h55);
      checks++; if (m1_rstb !== 1'b0) fail("mr_new_m1_rstb", m1_rstb, 1'b0);
      tick();
      mi_rstb = 1'b0; mi_rlast = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) fail("mr_new_busy_after", busy, 1'b0);

      // starvation: both valid forever, controller accepts and ends each burst at once
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      m0_addr = 24'h000700; m0_len = 7'd0; m0_rw = 1'b1; m0_valid = 1'b1;
      m1_addr = 24'h000800; m1_len = 7'd0; m1_rw = 1'b1; m1_valid = 1'b1;
      mi_ready = 1'b1; mi_rstb = 1'b1; mi_rlast = 1'b1;
      first0 = -1;
      m1n = 0;
      for (int k = 0; k < 40 && first0 < 0; k++) begin
         #1;
         if (m1_ready === 1'b1) m1n++;
         if (m0_ready === 1'b1) first0 = k;
         if (k == 18) begin
            checks++; if (dut.u_prio.wait0 !== 5'd16) fail("sv_wait0_full", dut.u_prio.wait0, 5'd16);
            checks++; if (busy !== 1'b0) fail("sv_idle_at_force", busy, 1'b0);
         end
         if (k == 19) begin
            checks++; if (dut.u_prio.wait0 !== 5'd0) fail("sv_wait0_clear", dut.u_prio.wait0, 5'd0);
            checks++; if (mi_addr !== 24'h000700) fail("sv_m0_addr", mi_addr, 24'h000700);
         end
         tick();
      end
      checks++; if (first0 !== 19) fail("sv_m0_grant_cycle", first0, 19);
      checks++; if (m1n !== 6) fail("sv_m1_bursts", m1n, 6);
      m0_valid = 1'b0; m1_valid = 1'b0; mi_ready = 1'b0;
      tick();
      mi_rstb = 1'b0; mi_rlast = 1'b0;
      tick();
      #1;
      checks++; if (busy !== 1'b0) fail("sv_busy_end", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
